// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   rx_state_e  - receiver FSM state encoding (also exported on the debug port)
//   parity_bit  - the parity bit a transmitter appends to a data word
//                 (data is zero-extended to MAX_DATA_WIDTH; even=1 selects even parity)
package uart_pkg;

  localparam int unsigned MAX_DATA_WIDTH = 9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } rx_state_e;

  // Even parity: bit makes the total count of ones even. Odd parity: total odd.
  function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data,
                                      input logic                      even);
    return even ? (^data) : ~(^data);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: line front end for uart_rx.
//   clk, rst    - clock, asynchronous active-low reset
//   rx          - raw asynchronous serial line (idle high)
//   restart     - current cycle is phase 0 of a new start bit; realigns the phase counter
//   run         - receiver is inside a frame; phase counter and vote advance
//   fall        - falling edge seen on the synchronized line
//   bit_valid   - one-cycle pulse when a bit has been decided
//   bit_value   - majority-voted value, valid with bit_valid
//   rx_sync     - synchronized line level (only with UART_RX_BREAK_DET_EN)
module uart_rx_sampler #(
  parameter int PRESCALER       = 16,
  parameter int LATCH_TOLERANCE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic restart,
  input  logic run,
  output logic fall,
`ifdef UART_RX_BREAK_DET_EN
  output logic rx_sync,
`endif
  output logic bit_valid,
  output logic bit_value
);

  localparam int PW = $clog2(PRESCALER);
  localparam int VW = $clog2(2 * LATCH_TOLERANCE + 2);
  localparam logic [PW-1:0] WIN_LO = PW'(PRESCALER / 2 - LATCH_TOLERANCE);
  localparam logic [PW-1:0] WIN_HI = PW'(PRESCALER / 2 + LATCH_TOLERANCE);
  localparam logic [PW-1:0] LAST   = PW'(PRESCALER - 1);

  logic          meta_q, sync_q, prev_q;
  logic [PW-1:0] phase_q, phase_d;
  logic [VW-1:0] ones_q, ones_d, ones_now;
  logic          in_win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      phase_q <= '0;
      ones_q  <= '0;
    end else begin
      meta_q  <= rx;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      phase_q <= phase_d;
      ones_q  <= ones_d;
    end
  end

  assign fall   = prev_q & ~sync_q;
  assign in_win = (phase_q >= WIN_LO) && (phase_q <= WIN_HI);
  // The sample on the decision cycle itself is part of the vote.
  assign ones_now  = in_win ? (ones_q + VW'(sync_q)) : ones_q;
  assign bit_valid = run && !restart && (phase_q == WIN_HI);
  assign bit_value = (ones_now > VW'(LATCH_TOLERANCE));
`ifdef UART_RX_BREAK_DET_EN
  assign rx_sync = sync_q;
`endif

  always_comb begin
    phase_d = phase_q;
    ones_d  = ones_q;
    if (restart) begin
      // The edge cycle is phase 0, so the next cycle is phase 1.
      phase_d = PW'(1);
      ones_d  = '0;
    end else if (run) begin
      phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
      ones_d  = (phase_q == LAST) ? '0 : ones_now;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with majority-vote bit sampling.
//   clk, rst   - clock, asynchronous active-low reset
//   rx         - serial line, idle high, LSB first
//   rxd        - last received word
//   rxv        - one-cycle pulse when rxd/perr/ferr are updated
//   perr/ferr  - parity / framing error of that word, qualified by rxv
//   brk        - break (all bits 0) flag pulsed with rxv; present only when
//                UART_RX_BREAK_DET_EN is defined
//   busy       - receiver is inside a frame
//   state_dbg  - current FSM state
// Handshake: rxv is a valid-only strobe; there is no ready, a new frame
// simply overwrites rxd.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int STOP_BITS       = 1,
  parameter int PARITY          = 1,
  parameter int EVEN            = 0,
  parameter int PRESCALER       = 16,
  parameter int LATCH_TOLERANCE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rxd,
  output logic                  rxv,
  output logic                  perr,
  output logic                  ferr,
`ifdef UART_RX_BREAK_DET_EN
  output logic                  brk,
`endif
  output logic                  busy,
  output rx_state_e             state_dbg
);

  rx_state_e             state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, rxd_q, rxd_d;
  logic                  pe_q, pe_d, fe_q, fe_d;
  logic                  rxv_q, rxv_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                  restart, run, fall, bit_valid, bit_value, hold;
  logic [MAX_DATA_WIDTH-1:0] data_ext;

`ifdef UART_RX_BREAK_DET_EN
  localparam int PW = $clog2(PRESCALER);
  logic          rx_sync;
  logic          zero_q, zero_d, brk_q, brk_d, hold_q, hold_d;
  logic [PW-1:0] hicnt_q, hicnt_d;
`endif

  assign run      = (state_q != IDLE);
  assign data_ext = MAX_DATA_WIDTH'(data_q);

  uart_rx_sampler #(
    .PRESCALER      (PRESCALER),
    .LATCH_TOLERANCE(LATCH_TOLERANCE)
  ) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .restart  (restart),
    .run      (run),
    .fall     (fall),
`ifdef UART_RX_BREAK_DET_EN
    .rx_sync  (rx_sync),
`endif
    .bit_valid(bit_valid),
    .bit_value(bit_value)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      rxd_q   <= '0;
      rxv_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      rxd_q   <= rxd_d;
      rxv_q   <= rxv_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    rxd_d   = rxd_q;
    rxv_d   = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    restart = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall && !hold) begin
          state_d = START;
          cnt_d   = '0;
          pe_d    = 1'b0;
          fe_d    = 1'b0;
          restart = 1'b1;
        end
      end
      START: begin
        if (bit_valid) begin
          // A start bit that votes high was a glitch: drop it silently.
          state_d = bit_value ? IDLE : DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (bit_valid) begin
          data_d = {bit_value, data_q[DATA_WIDTH-1:1]};
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'(DATA_WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end
        end
      end
      PAR: begin
        if (bit_valid) begin
          pe_d    = (bit_value != parity_bit(data_ext, EVEN != 0));
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_valid) begin
          fe_d  = fe_q | ~bit_value;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(STOP_BITS - 1)) begin
            // Returning to IDLE here, mid stop bit, lets the next start
            // edge of a back-to-back frame be caught.
            state_d = IDLE;
            cnt_d   = '0;
            rxv_d   = 1'b1;
            rxd_d   = data_q;
            perr_d  = pe_q;
            ferr_d  = fe_q | ~bit_value;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_RX_BREAK_DET_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zero_q  <= 1'b0;
      brk_q   <= 1'b0;
      hold_q  <= 1'b0;
      hicnt_q <= '0;
    end else begin
      zero_q  <= zero_d;
      brk_q   <= brk_d;
      hold_q  <= hold_d;
      hicnt_q <= hicnt_d;
    end
  end

  // zero_q tracks "every data/parity/stop bit so far voted 0".
  // After a break, hold_q blocks new frames until the line has been
  // high for a full bit time.
  always_comb begin
    zero_d  = zero_q;
    brk_d   = 1'b0;
    hold_d  = hold_q;
    hicnt_d = hicnt_q;
    if (restart) zero_d = 1'b1;
    if (bit_valid && (state_q == DATA || state_q == PAR || state_q == STOP))
      zero_d = zero_q & ~bit_value;
    if (rxv_d) begin
      brk_d   = zero_q & ~bit_value;
      hold_d  = zero_q & ~bit_value;
      hicnt_d = '0;
    end else if (hold_q && state_q == IDLE) begin
      hicnt_d = rx_sync ? hicnt_q + PW'(1) : '0;
      if (rx_sync && hicnt_q == PW'(PRESCALER - 1)) hold_d = 1'b0;
    end
  end

  assign hold = hold_q;
  assign brk  = brk_q;
`else
  assign hold = 1'b0;
`endif

  assign rxd       = rxd_q;
  assign rxv       = rxv_q;
  assign perr      = perr_q;
  assign ferr      = ferr_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame (5..9), sent LSB first.
REQ-002 The block SHALL have parameter STOP_BITS, default 1, meaning required stop bits (1 or 2).
REQ-003 The block SHALL have parameter PARITY, default 1, meaning a parity bit follows the data bits (0 = none).
REQ-004 The block SHALL have parameter EVEN, default 0, meaning even parity when 1 and odd parity when 0.
REQ-005 The block SHALL have parameter PRESCALER, default 16, meaning clk cycles per bit (even, >= 8).
REQ-006 The block SHALL have parameter LATCH_TOLERANCE, default 2, meaning half-width of the majority-vote window in clk cycles (< PRESCALER/4).
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-009 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-010 The block SHALL have port rxd, output, DATA_WIDTH bits: the last received word.
REQ-011 The block SHALL have port rxv, output, 1 bit: a one-cycle pulse when rxd is updated.
REQ-012 The block SHALL have port perr, output, 1 bit: parity error, qualified by rxv.
REQ-013 The block SHALL have port ferr, output, 1 bit: stop-bit (framing) error, qualified by rxv.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer; all references to rx below mean the synchronized value.
REQ-016 The state machine SHALL have the states IDLE, START, DATA, PAR, STOP.
- IDLE->START on a falling edge of rx; the bit counter clears to 0.
REQ-017 Each bit SHALL be decided by majority vote of 2*LATCH_TOLERANCE+1 samples centred on bit cycle PRESCALER/2; the decision is taken at cycle PRESCALER/2+LATCH_TOLERANCE.
REQ-018 START SHALL go to DATA if the voted start bit is 0; otherwise it returns to IDLE (glitch rejection) with no rxv.
REQ-019 DATA SHALL shift in DATA_WIDTH voted bits LSB first, then go to PAR if PARITY=1, otherwise to STOP.
REQ-020 PAR SHALL set the internal parity error when the XOR of data and parity bits is not equal to ~EVEN; i.e. even parity requires an even count of ones, odd parity an odd count.
REQ-021 STOP SHALL vote STOP_BITS bits; any 0 sets the framing error.
REQ-022 On the last stop-bit decision, the block SHALL go to IDLE and, one cycle later, update rxd, perr and ferr and pulse rxv for exactly one cycle.
REQ-023 Frames with errors SHALL still be delivered; rxd holds the received bits.
REQ-024 A falling edge during the second half of the last stop bit SHALL be detected by IDLE with no frame lost; back-to-back frames are supported.
REQ-025 There is no backpressure: rxd SHALL be overwritten by the next frame.

Reset
REQ-026 rst low SHALL immediately force the state to IDLE, clear the counters, set both synchronizer flops to 1, and drive rxd=0, rxv=0, perr=0, ferr=0 and busy=0.
REQ-027 Reset asserted mid-frame SHALL discard the frame (no rxv); after release, reception restarts only on a new falling edge.

Configuration
REQ-028 With UART_RX_BREAK_DET_EN defined, the block SHALL add an output brk (1 bit, reset 0) that pulses with rxv when all data, parity and stop bits voted 0; after that pulse, IDLE ignores rx until rx has been high for PRESCALER cycles.
REQ-029 Without UART_RX_BREAK_DET_EN, the block SHALL have no brk port, and a break SHALL appear only as ferr=1 with rxd=0.

Structure
REQ-030 Package uart_pkg SHALL hold the rx state enum and a parity function (data, even) -> bit shared with the transmitter.
REQ-031 A sub-module uart_rx_sampler SHALL contain the synchronizer, bit-phase counter and majority vote, and output a one-cycle bit_valid pulse with bit_value.

Verification
REQ-032 The bench SHALL use the defaults, transmit 0x3A with parity bit 1 and one stop bit, and check for exactly one rxv with rxd=0x3A, perr=0, ferr=0, about 176 cycles after the start edge.
REQ-033 The bench SHALL repeat 0x3A with parity bit 0 and check for rxv with rxd=0x3A and perr=1.
REQ-034 The bench SHALL drive rx low for 4 cycles, then high, and check that there is no rxv and busy returns to 0 within PRESCALER cycles.
REQ-035 The bench SHALL send 0x55 with stop bit 0 and check for rxv with ferr=1 and rxd=0x55; with the macro defined, it sends all zeros and checks that brk=1.
REQ-036 The bench SHALL send 0xA5 and 0x5A back-to-back with no idle gap and check for two rxv pulses carrying the correct data.
REQ-037 The bench SHALL assert rst in the middle of the DATA state and check that all outputs are 0 and there is no rxv; a following 0x3C frame SHALL be received correctly.
